stream_demux_1to2: RTL and testbench
====================================

STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 The module SHALL have parameter size, default 32: width of the data path in bits.
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-004 The module SHALL have port data_i, input, size bits: the incoming word.
REQ-005 The module SHALL have port select_i, input, 1 bit: destination of data_i (0 routes to channel 0, 1 routes to channel 1).
REQ-006 The module SHALL have port valid_i, input, 1 bit: data_i/select_i are valid.
REQ-007 The module SHALL have port ready_o, output, 1 bit: the word is accepted this cycle.
REQ-008 The module SHALL have ports data0_o, output, size bits, and data1_o, output, size bits: the buffered word of each channel.
REQ-009 The module SHALL have ports valid0_o, output, 1 bit, and valid1_o, output, 1 bit: the channel buffer holds a word.
REQ-010 The module SHALL have ports ready0_i, input, 1 bit, and ready1_i, input, 1 bit: the downstream consumer takes the word.

Function
REQ-011 Each channel SHALL contain one buffer slot with two states: EMPTY (valid=0) and FULL (valid=1).
REQ-012 An input transfer SHALL occur when valid_i=1 and ready_o=1.
REQ-013 An output transfer on channel n SHALL occur when validn_o=1 and readyn_i=1.
REQ-014 ready_o SHALL be combinational: 1 when the slot selected by select_i is EMPTY, or FULL and draining this cycle; otherwise 0.
REQ-015 ready_o SHALL NOT depend on the state of the non-selected channel.
REQ-016 On an input transfer, the selected slot SHALL capture data_i and be FULL on the next cycle.
REQ-017 Latency from input transfer to validn_o=1 SHALL be exactly 1 cycle.
REQ-018 A slot SHALL go from FULL to EMPTY after an output transfer with no simultaneous input transfer to that slot.
REQ-019 A simultaneous drain and fill of the same slot SHALL keep it FULL and load the new word, with no bubble.
REQ-020 The non-selected slot SHALL hold its data and state unless it drains.
REQ-021 datan_o SHALL remain stable while validn_o=1 and readyn_i=0.
REQ-022 Both channels SHALL drain independently in the same cycle.
REQ-023 valid_i=0 SHALL cause no state change beyond output drains, regardless of select_i.
REQ-024 Words on each channel SHALL be delivered in input order, with none lost or duplicated.

Reset
REQ-025 While rst_i=1 at a clock edge, both slots SHALL become EMPTY: valid0_o=0, valid1_o=0, data0_o=0, data1_o=0.
REQ-026 Reset SHALL take priority over any simultaneous input or output transfer, and buffered words SHALL be discarded.
REQ-027 During rst_i=1, ready_o SHALL be forced to 0 so that no transfer is reported.

Configuration
REQ-028 With macro STREAM_DEMUX_CNT_EN defined, outputs count0_o and count1_o (each 16 bits) SHALL count output transfers per channel, wrap from 0xFFFF to 0, and reset to 0.
REQ-029 Without STREAM_DEMUX_CNT_EN, the count ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then valid_i=1, select_i=0, data_i=0xA5A5A5A5, with ready0_i=1 -> next cycle valid0_o=1, data0_o=0xA5A5A5A5, valid1_o=0; one cycle later valid0_o=0.
REQ-031 Channel 1 FULL with 0x11 and ready1_i=0, then input select_i=1 -> ready_o=0 and data1_o holds 0x11; same state with input select_i=0 -> ready_o=1 and channel 0 loads.
REQ-032 Back-to-back inputs 0x1, 0x2, 0x3 to channel 0 with ready0_i=1 -> ready_o stays 1; data0_o shows 0x1, 0x2, 0x3 on consecutive cycles.
REQ-033 Both slots FULL, ready0_i=ready1_i=1, with a new input to channel 1 -> channel 0 EMPTY, channel 1 FULL with the new word.
REQ-034 rst_i=1 asserted with both slots FULL and an input pending -> next cycle both valids are 0 and no transfer is counted.
REQ-035 With STREAM_DEMUX_CNT_EN defined, 65537 transfers on channel 0 -> count0_o=1 and count1_o=0.

Source files
------------

// File: rtl/stream_demux_1to2.sv
// 1-to-2 stream demultiplexer with a single-entry buffer slot per output channel.
// Optional per-channel output-transfer counters are enabled with STREAM_DEMUX_CNT_EN.
//
// state      | meaning
// SLOT_EMPTY | channel slot holds no word, validn_o=0
// SLOT_FULL  | channel slot holds a word, validn_o=1
module stream_demux_1to2 #(
  parameter int size = 32
) (
  input  logic            clk_i,
`ifdef STREAM_DEMUX_CNT_EN
  output logic [15:0]     count0_o,
  output logic [15:0]     count1_o,
`endif
  input  logic            rst_i,
  input  logic [size-1:0] data_i,
  input  logic            select_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [size-1:0] data0_o,
  output logic [size-1:0] data1_o,
  output logic            valid0_o,
  output logic            valid1_o,
  input  logic            ready0_i,
  input  logic            ready1_i
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  slot_e           slot_q [2];
  slot_e           slot_d [2];
  logic [size-1:0] data_q [2];
  logic [size-1:0] data_d [2];
  logic [1:0]      rdy_dn;
  logic [1:0]      drain;
  logic [1:0]      fill;
  logic            sel_free;

  assign rdy_dn = {ready1_i, ready0_i};

  always_comb begin
    drain    = '0;
    fill     = '0;
    sel_free = 1'b0;
    ready_o  = 1'b0;
    for (int n = 0; n < 2; n++) begin
      slot_d[n] = slot_q[n];
      data_d[n] = data_q[n];
    end

    for (int n = 0; n < 2; n++)
      drain[n] = (slot_q[n] == SLOT_FULL) && rdy_dn[n];

    // Acceptance looks only at the addressed slot, so a stalled neighbour never blocks.
    sel_free = (slot_q[select_i] == SLOT_EMPTY) || drain[select_i];
    ready_o  = !rst_i && sel_free;

    fill[0] = valid_i && ready_o && !select_i;
    fill[1] = valid_i && ready_o &&  select_i;

    for (int n = 0; n < 2; n++) begin
      if (fill[n]) begin
        slot_d[n] = SLOT_FULL;
        data_d[n] = data_i;
      end else if (drain[n]) begin
        slot_d[n] = SLOT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < 2; n++) begin
        slot_q[n] <= SLOT_EMPTY;
        data_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        slot_q[n] <= slot_d[n];
        data_q[n] <= data_d[n];
      end
    end
  end

  assign valid0_o = (slot_q[0] == SLOT_FULL);
  assign valid1_o = (slot_q[1] == SLOT_FULL);
  assign data0_o  = data_q[0];
  assign data1_o  = data_q[1];

`ifdef STREAM_DEMUX_CNT_EN
  logic [15:0] cnt_q [2];

  // Counters wrap naturally at 16 bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      for (int n = 0; n < 2; n++)
        if (drain[n]) cnt_q[n] <= cnt_q[n] + 16'd1;
    end
  end

  assign count0_o = cnt_q[0];
  assign count1_o = cnt_q[1];
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Randomized and directed bench for stream_demux_1to2 against a queue-based reference.
// Counter checks are included when STREAM_DEMUX_CNT_EN is defined.
module tb_stream_demux_1to2;

  localparam int size = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [size-1:0] data_i;
  logic            select_i;
  logic            valid_i;
  logic            ready_o;
  logic [size-1:0] data0_o;
  logic [size-1:0] data1_o;
  logic            valid0_o;
  logic            valid1_o;
  logic            ready0_i;
  logic            ready1_i;
`ifdef STREAM_DEMUX_CNT_EN
  logic [15:0]     count0_o;
  logic [15:0]     count1_o;
`endif

  stream_demux_1to2 #(.size(size)) dut (
    .clk_i    (clk_i),
`ifdef STREAM_DEMUX_CNT_EN
    .count0_o (count0_o),
    .count1_o (count1_o),
`endif
    .rst_i    (rst_i),
    .data_i   (data_i),
    .select_i (select_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data0_o  (data0_o),
    .data1_o  (data1_o),
    .valid0_o (valid0_o),
    .valid1_o (valid1_o),
    .ready0_i (ready0_i),
    .ready1_i (ready1_i)
  );

  always #5 clk_i = ~clk_i;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference: each channel is a queue of at most one word; sent_q records every accepted word.
  logic [size-1:0] buf_q  [2][$];
  logic [size-1:0] sent_q [2][$];
  int              m_cnt  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      buf_q[n].delete();
      sent_q[n].delete();
      m_cnt[n] = 0;
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [size-1:0] d,
                      input logic r0, input logic r1, input logic rs);
    logic            exp_rdy;
    logic [1:0]      rdn;
    logic [1:0]      obs_v;
    logic [size-1:0] obs_d [2];
    logic [size-1:0] w;
    valid_i = v; select_i = s; data_i = d; ready0_i = r0; ready1_i = r1; rst_i = rs;
    #1;
    rdn = {r1, r0};
    obs_v = {valid1_o, valid0_o};
    obs_d[0] = data0_o;
    obs_d[1] = data1_o;
    exp_rdy = !rs && ((buf_q[s].size() == 0) || rdn[s]);
    chk("ready_o", 64'(ready_o), 64'(exp_rdy));
    chk("valid0", 64'(valid0_o), 64'(buf_q[0].size() != 0));
    chk("valid1", 64'(valid1_o), 64'(buf_q[1].size() != 0));
    if (buf_q[0].size() != 0) chk("data0", 64'(data0_o), 64'(buf_q[0][0]));
    if (buf_q[1].size() != 0) chk("data1", 64'(data1_o), 64'(buf_q[1][0]));
`ifdef STREAM_DEMUX_CNT_EN
    chk("count0", 64'(count0_o), 64'(m_cnt[0] % 65536));
    chk("count1", 64'(count1_o), 64'(m_cnt[1] % 65536));
`endif
    if (rs) begin
      model_reset();
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (obs_v[n] && rdn[n]) begin
          if (sent_q[n].size() == 0) begin
            chk("order_underflow", 64'(obs_d[n]), 64'hDEAD);
          end else begin
            w = sent_q[n].pop_front();
            chk("order", 64'(obs_d[n]), 64'(w));
          end
        end
        if (buf_q[n].size() != 0 && rdn[n]) begin
          void'(buf_q[n].pop_front());
          m_cnt[n]++;
        end
        if (v && exp_rdy && (int'(s) == n)) begin
          buf_q[n].push_back(d);
          sent_q[n].push_back(d);
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; select_i = 1'b0; data_i = '0;
    ready0_i = 1'b0; ready1_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    step(1'b1, 1'b0, 32'h1234, 1'b0, 1'b0, 1'b1);
    chk("rst_data0", 64'(data0_o), 64'h0);
    chk("rst_data1", 64'(data1_o), 64'h0);

    // Single word through channel 0 with 1-cycle latency
    step(1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);

    // Stalled channel 1 blocks only inputs addressed to it
    step(1'b1, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    chk("ch1_hold", 64'(data1_o), 64'h11);
    step(1'b1, 1'b0, 32'h33, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

    // Back-to-back on channel 0
    step(1'b1, 1'b0, 32'h1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Both full, dual drain with refill of channel 1
    step(1'b1, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h66, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("dual_v0", 64'(valid0_o), 64'h0);
    chk("dual_d1", 64'(data1_o), 64'h66);

    // Reset beats pending transfers
    step(1'b1, 1'b0, 32'h77, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h88, 1'b1, 1'b1, 1'b1);
    chk("rst_v0", 64'(valid0_o), 64'h0);
    chk("rst_v1", 64'(valid1_o), 64'h0);

    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 63) == 0));

`ifdef STREAM_DEMUX_CNT_EN
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 65537; i++)
      step(1'b1, 1'b0, 32'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("wrap_cnt0", 64'(count0_o), 64'h1);
    chk("wrap_cnt1", 64'(count1_o), 64'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
